// File: rtl/gpu_loader_pkg.sv
// Shared definitions for the host command loader: command codes, loader
// states and the length of the core reset pulse issued by STOP.
package gpu_loader_pkg;

    localparam logic [7:0] CMD_WRITE_INST = 8'h01;
    localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
    localparam logic [7:0] CMD_RUN        = 8'h03;
    localparam logic [7:0] CMD_STOP       = 8'h04;

    localparam int STOP_RESET_CYCLES = 2;

    // Index of the final byte of a 32-bit little-endian word.
    localparam logic [1:0] LAST_BYTE_INDEX = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_LEN0,
        S_LEN1,
        S_PAYLOAD,
        S_WRITE,
        S_RUNNING
    } loader_state_t;

endpackage

// File: rtl/gpu_loader_word_assembler.sv
// Packs payload bytes little-endian into a 32-bit word and flags the cycle
// on which the fourth byte arrives.
module word_assembler
    import gpu_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift) begin
            word  <= {data_byte, word[31:8]};
            count <= count + 2'd1;
        end
    end

    assign word_complete = shift && (count == LAST_BYTE_INDEX);

endmodule

// File: rtl/gpu_loader.sv
// Host byte-stream command loader: parses write/run/stop frames and drives
// the shader core's RAM write strobes, run level and core reset.
module gpu_loader
    import gpu_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               host_data,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     core_halted,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [WORD_WIDTH-1:0]    ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     core_run,
    output logic                     core_reset_n,
    output logic                     done,
    output logic                     error
);

    loader_state_t            state, state_next;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [15:0]              len;
    logic                     is_inst;
    logic                     init_done;
    logic [1:0]               stop_count;
    logic                     pulse_active;
    logic                     accept;
    logic                     frame_start;
    logic                     set_error;
    logic                     start_run;
    logic                     stop_core;
    logic                     word_complete;
    logic [WORD_WIDTH-1:0]    word;

    assign pulse_active = (stop_count != 2'd0);
    assign host_ready   = init_done && !pulse_active && (state != S_WRITE);
    assign accept       = host_valid && host_ready;
    assign core_reset_n = init_done && !pulse_active;

    assign ext_write_address = address;
    assign ext_write_data    = word;

    word_assembler u_word_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (frame_start),
        .shift         (accept && (state == S_PAYLOAD)),
        .data_byte     (host_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can infer a latch.
    always_comb begin
        state_next            = state;
        frame_start           = 1'b0;
        set_error             = 1'b0;
        start_run             = 1'b0;
        stop_core             = 1'b0;
        ext_enable_write_inst = 1'b0;
        ext_enable_write_data = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                case (host_data)
                    CMD_WRITE_INST, CMD_WRITE_DATA: begin
                        state_next  = S_ADDR0;
                        frame_start = 1'b1;
                    end
                    CMD_RUN: begin
                        state_next = S_RUNNING;
                        start_run  = 1'b1;
                    end
                    CMD_STOP: stop_core = 1'b1;
                    default:  set_error = 1'b1;
                endcase
            end
            S_ADDR0: if (accept) state_next = S_ADDR1;
            S_ADDR1: if (accept) state_next = S_LEN0;
            S_LEN0:  if (accept) state_next = S_LEN1;
            S_LEN1: if (accept) begin
                state_next = ({host_data, len[7:0]} != 16'd0) ? S_PAYLOAD : S_IDLE;
            end
            S_PAYLOAD: if (word_complete) state_next = S_WRITE;
            S_WRITE: begin
                // Gated by core_run as a guard: RAMs must never be written under a running core.
                ext_enable_write_inst = is_inst && !core_run;
                ext_enable_write_data = !is_inst && !core_run;
                state_next = (len == 16'd1) ? S_IDLE : S_PAYLOAD;
            end
            S_RUNNING: if (accept) begin
                if (host_data == CMD_STOP) begin
                    stop_core  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    set_error = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            address    <= '0;
            len        <= '0;
            is_inst    <= 1'b0;
            init_done  <= 1'b0;
            stop_count <= '0;
            core_run   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (set_error) error <= 1'b1;

            if (stop_core) begin
                stop_count <= 2'(STOP_RESET_CYCLES);
                core_run   <= 1'b0;
            end else begin
                if (pulse_active) stop_count <= stop_count - 2'd1;
                if (start_run)    core_run   <= 1'b1;
            end
            done <= core_run && core_halted && !stop_core;

            if (frame_start) is_inst <= (host_data == CMD_WRITE_INST);

            if (accept) begin
                case (state)
                    S_ADDR0: address <= ADDRESS_WIDTH'({host_data[7:2], 2'b00});
                    S_ADDR1: address <= address | ADDRESS_WIDTH'({host_data, 8'h00});
                    S_LEN0:  len     <= {8'h00, host_data};
                    S_LEN1:  len     <= {host_data, len[7:0]};
                    default: ;
                endcase
            end

            if (state == S_WRITE) begin
                address <= address + ADDRESS_WIDTH'(4);
                len     <= len - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpu_loader.sv
// Self-checking bench for gpu_loader: directed frames plus randomized frames
// scored against a frame-level model of the expected RAM writes.
module tb_gpu_loader;

    localparam logic [7:0] C_INST = 8'h01;
    localparam logic [7:0] C_DATA = 8'h02;
    localparam logic [7:0] C_RUN  = 8'h03;
    localparam logic [7:0] C_STOP = 8'h04;

    typedef struct packed {
        logic        inst_en;
        logic        data_en;
        logic        ready;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  host_data;
    logic        host_valid;
    logic        host_ready;
    logic        core_halted;
    logic [15:0] ext_write_address;
    logic [31:0] ext_write_data;
    logic        ext_enable_write_inst;
    logic        ext_enable_write_data;
    logic        core_run;
    logic        core_reset_n;
    logic        done;
    logic        error;

    int  vectors     = 0;
    int  miscompares = 0;
    int  cycle       = 0;
    int  last_accept = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];

    gpu_loader dut (
        .clock                 (clock),
        .reset                 (reset),
        .host_data             (host_data),
        .host_valid            (host_valid),
        .host_ready            (host_ready),
        .core_halted           (core_halted),
        .ext_write_address     (ext_write_address),
        .ext_write_data        (ext_write_data),
        .ext_enable_write_inst (ext_enable_write_inst),
        .ext_enable_write_data (ext_enable_write_data),
        .core_run              (core_run),
        .core_reset_n          (core_reset_n),
        .done                  (done),
        .error                 (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Capture every write strobe in the middle of its cycle.
    always @(negedge clock) begin
        if (ext_enable_write_inst || ext_enable_write_data)
            obs_q.push_back('{inst_en: ext_enable_write_inst, data_en: ext_enable_write_data,
                              ready: host_ready, addr: ext_write_address,
                              data: ext_write_data, cyc: cycle});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clock);
        host_data  = b;
        host_valid = 1'b1;
        waited     = 0;
        while (!host_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!host_ready) check("host_ready_timeout", host_ready, 1);
        last_accept = cycle;
        @(negedge clock);
        host_valid = 1'b0;
    endtask

    // Reference model: a frame writes len consecutive words starting at the
    // word-aligned header address, wrapping at 64 KiB.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] a,
                              input logic [15:0] n, input logic [7:0] pl[$], input bit gaps);
        logic [7:0]  hdr [5];
        logic [31:0] w_val;
        hdr = '{cmd, a[7:0], a[15:8], n[7:0], n[15:8]};
        foreach (hdr[i]) send_byte(hdr[i], gaps ? int'($urandom_range(2, 0)) : 0);
        for (int w = 0; w < int'(n); w++) begin
            w_val = 32'd0;
            for (int k = 0; k < 4; k++) begin
                send_byte(pl[4*w+k], gaps ? int'($urandom_range(2, 0)) : 0);
                w_val = w_val + (32'(pl[4*w+k]) << (8 * k));
            end
            exp_q.push_back('{inst_en: (cmd == C_INST), data_en: (cmd == C_DATA), ready: 1'b0,
                              addr: 16'((int'(a) / 4 * 4 + 4 * w) % 65536),
                              data: w_val, cyc: 32'(last_accept + 1)});
        end
    endtask

    task automatic verify_writes(input string tag);
        wr_t o, e;
        repeat (3) @(negedge clock);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_strobes"}, {o.inst_en, o.data_en, o.ready}, {e.inst_en, e.data_en, e.ready});
            check({tag, "_addr"}, o.addr, e.addr);
            check({tag, "_data"}, o.data, e.data);
            check({tag, "_cycle"}, o.cyc, e.cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {host_ready, ext_write_address, ext_write_data, ext_enable_write_inst,
                    ext_enable_write_data, core_run, core_reset_n, done, error}, 64'd0);
    endtask

    // Called right after a STOP byte was accepted (we sit at cycle N+1).
    task automatic check_stop_pulse(input string tag);
        check({tag, "_n1"}, {core_run, core_reset_n, host_ready, done}, 4'b0000);
        @(negedge clock);
        check({tag, "_n2"}, {core_run, core_reset_n, host_ready}, 3'b000);
        @(negedge clock);
        check({tag, "_n3"}, {core_run, core_reset_n, host_ready}, 3'b011);
    endtask

    task automatic random_payload(input int words, output logic [7:0] pl[$]);
        pl = {};
        for (int i = 0; i < 4 * words; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0]  pl[$];
        logic [15:0] n;

        reset       = 1'b1;
        host_valid  = 1'b0;
        host_data   = 8'h00;
        core_halted = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_values");
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", {host_ready, core_reset_n}, 2'b11);

        pl = {8'h13, 8'h00, 8'h10, 8'h00};
        send_frame(C_INST, 16'h0000, 16'd1, pl, 1'b0);
        verify_writes("inst_single");

        random_payload(2, pl);
        send_frame(C_DATA, 16'h0106, 16'd2, pl, 1'b0);
        verify_writes("data_masked");

        random_payload(2, pl);
        send_frame(C_INST, 16'hFFFC, 16'd2, pl, 1'b0);
        verify_writes("addr_wrap");

        pl = {};
        send_frame(C_INST, 16'h0010, 16'd0, pl, 1'b0);
        verify_writes("len_zero");

        for (int f = 0; f < 6; f++) begin
            n = 16'($urandom_range(3, 1));
            random_payload(int'(n), pl);
            send_frame(($urandom_range(1, 0) != 0) ? C_INST : C_DATA, 16'($urandom), n, pl, 1'b1);
            verify_writes("random_frame");
        end

        // Abort a frame after two payload bytes.
        foreach (pl[i]) pl[i] = 8'hA5;
        send_byte(C_DATA, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        verify_writes("midframe_abort");
        random_payload(1, pl);
        send_frame(C_DATA, 16'($urandom), 16'd1, pl, 1'b0);
        verify_writes("after_abort");

        send_byte(C_STOP, 0);
        check_stop_pulse("stop_idle");
        check("stop_idle_no_error", error, 0);

        send_byte(8'h7F, 0);
        check("bad_cmd_error", error, 1);
        random_payload(1, pl);
        send_frame(C_INST, 16'($urandom), 16'd1, pl, 1'b0);
        verify_writes("after_bad_cmd");

        check("run_before", core_run, 0);
        send_byte(C_RUN, 0);
        check("run_level", core_run, 1);
        repeat (9) @(negedge clock);
        core_halted = 1'b1;
        check("done_before_halt_seen", done, 0);
        @(negedge clock);
        check("done_after_halt", done, 1);
        send_byte(C_INST, 0);
        repeat (6) @(negedge clock);
        check("running_bad_byte", {error, core_run, done}, 3'b111);
        verify_writes("running_no_strobe");
        send_byte(C_STOP, 0);
        check_stop_pulse("stop_running");
        check("done_after_stop", done, 0);
        core_halted = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpu_loader.md
# gpu_loader

Host-side command loader that sits directly upstream of the shader core. It turns a byte stream from the host link into the core's external program/data write strobes, plus its run and reset controls. It lets the host load instruction RAM and data RAM, start execution, observe halt, and return the core to its load state without a full system reset.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, byte address width of core RAMs
- WORD_WIDTH, 32, RAM word width; must be 32 (4 bytes per word)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- host_data  in  8  command/payload byte
- host_valid  in  1  host_data valid this cycle
- host_ready  out  1  loader accepts byte when host_valid && host_ready
- core_halted  in  1  halt indication from core
- ext_write_address  out  ADDRESS_WIDTH  byte address for current write
- ext_write_data  out  WORD_WIDTH  assembled word
- ext_enable_write_inst  out  1  one-cycle instruction RAM write strobe
- ext_enable_write_data  out  1  one-cycle data RAM write strobe
- core_run  out  1  core run level
- core_reset_n  out  1  active-low core reset
- done  out  1  registered core_run && core_halted
- error  out  1  sticky protocol error

## Operation
- Commands (first byte of a frame):
  - 0x01 WRITE_INST, 0x02 WRITE_DATA: followed by addr_lo, addr_hi, len_lo, len_hi (len in words), then 4*len payload bytes, each word little-endian.
  - 0x03 RUN: one byte.
  - 0x04 STOP: one byte.
  - Any other value: sets error, byte discarded, stay in IDLE.
- States: IDLE, ADDR0, ADDR1, LEN0, LEN1, PAYLOAD, WRITE, RUNNING.
  - IDLE→ADDR0 on write command; ADDR0→ADDR1→LEN0→LEN1, one accepted byte each.
  - LEN1→PAYLOAD if len≠0, else →IDLE.
  - PAYLOAD collects 4 bytes via 2-bit byte counter, then →WRITE.
  - WRITE lasts one cycle, decrements len, adds 4 to the address, then →PAYLOAD if len≠0, else →IDLE.
- Address: addr[1:0] forced to 0 at header capture. Increment wraps modulo 2^ADDRESS_WIDTH. Len is 16-bit; 0xFFFF is legal.
- RUN in IDLE: core_run←1, →RUNNING.
- In RUNNING, only STOP is honoured: core_run←0, core_reset_n←0 for exactly 2 cycles, →IDLE. Any other byte sets error and is discarded (no header parsing).
- STOP in IDLE: same reset pulse, no error.
- Write strobes are never asserted while core_run=1.
- error clears only on reset.

## Timing
- Reset values: host_ready 0, ext_write_address 0, ext_write_data 0, both enables 0, core_run 0, core_reset_n 0, done 0, error 0, state IDLE.
- core_reset_n rises 1 cycle after reset deasserts; host_ready rises on the same cycle.
- host_ready is 1 in every state except WRITE and during the STOP reset pulse.
- Byte accepted on cycle N (4th payload byte) → state WRITE on N+1. On N+1 the selected enable is 1 for exactly one cycle, with address and data stable on that cycle.
- Minimum frame-to-strobe spacing: 5 cycles per word.
- Back-to-back host_valid is fully supported. A host_valid gap holds all state.
- RUN accepted on N → core_run=1 on N+1.
- STOP accepted on N → core_run=0 and core_reset_n=0 on N+1, N+2; core_reset_n=1 on N+3.
- done is registered: one cycle after core_halted is seen with core_run=1. It clears with core_run.
- Reset mid-frame aborts the frame, with no partial strobe. A partially assembled word is discarded.

## Structure
- Shared package gpu_loader_pkg: command codes CMD_WRITE_INST/CMD_WRITE_DATA/CMD_RUN/CMD_STOP, loader state enum, STOP_RESET_CYCLES=2.
- One sub-module: word_assembler. It shifts in bytes little-endian, counts 0..3 and flags word_complete; it is cleared by the parent on frame start and on reset.

## Test plan
- Send 01 00 00 01 00, then payload 13 00 10 00 → one ext_enable_write_inst pulse, addr 0x0000, data 0x00100013, the cycle after the last byte.
- Send 02 06 01 02 00 + 8 bytes → two data strobes, addr 0x0104 then 0x0108 (low bits masked), ≥5 cycles apart.
- Send 01 FC FF 02 00 + 8 bytes → addresses 0xFFFC then 0x0000 (wrap).
- Send 03; raise core_halted 10 cycles later → core_run=1 the cycle after accept, done=1 one cycle after halt. Then send 01 → error=1, no strobe. Then send 04 → core_reset_n low exactly 2 cycles, core_run=0, done=0.
- Send 0x7F in IDLE → error=1, state IDLE. Next valid frame still writes correctly.
- Assert reset after 2 of 4 payload bytes → no strobe, all outputs at reset values. A fresh frame then works.
